// File: rtl/ysyx_25030077_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25030077_pkg
//  Description : Shared definitions for the register file / write-back block:
//                data width, register address width, write-back source
//                select codes, FSM state encoding and load funct3 codes.
//  Revision    : 1.0  - initial release
// ============================================================================
package ysyx_25030077_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Write-back source select
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_PC4  = 2'd1;
    localparam logic [1:0] WB_SEL_LOAD = 2'd2;
    localparam logic [1:0] WB_SEL_CSR  = 2'd3;

    // Write-back FSM states
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LD_WAIT = 1'b1;

    // Load funct3 codes; every code not listed returns the full word
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Context of the single outstanding load, captured at accept
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic [1:0]        addr_lo;
    } ld_ctx_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_25030077_LOAD_EXT.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25030077_LOAD_EXT
//  Description : Combinational load data extraction and extension. Picks the
//                byte / halfword addressed by the low address bits out of the
//                memory word and sign- or zero-extends it to XLEN.
//  Ports       : i_funct3  - load type
//                i_addr_lo - byte offset within the word
//                i_rdata   - raw memory response word
//                o_data    - extended value to write back
//  Revision    : 1.0  - initial release
// ============================================================================
module ysyx_25030077_LOAD_EXT
    import ysyx_25030077_pkg::*;
#(
    parameter int XLEN = ysyx_25030077_pkg::XLEN
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane selected by both offset bits, half lane by the upper bit only
    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_25030077_reg_wb.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25030077_reg_wb
//  Description : Integer register file with write-back stage. Immediate
//                sources (ALU, pc+4, CSR) are written on the accept edge;
//                loads park the FSM in LD_WAIT until the memory response
//                arrives, during which dependent reads report busy.
//  Ports       : clock / reset         - clock, synchronous active-low reset
//                io_rs1/2_addr/data     - combinational read ports (bypassed)
//                io_busy_rs1/2          - source waits on the outstanding load
//                io_wb_valid/ready      - write-back request handshake
//                io_wb_rd/sel           - destination and source select
//                io_alu_result, io_pc_count, io_csr_data - write-back sources
//                io_ld_funct3/addr_lo   - load type and offset (at accept)
//                io_mem_rvalid/rdata/rready - memory load response channel
//                io_spurious            - sticky unexpected-response flag
//  Revision    : 1.0  - initial release
// ============================================================================
module ysyx_25030077_reg_wb
    import ysyx_25030077_pkg::*;
#(
    parameter int XLEN = ysyx_25030077_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] io_rs1_addr,
    input  logic [REG_AW-1:0] io_rs2_addr,
    output logic [XLEN-1:0]   io_rs1_data,
    output logic [XLEN-1:0]   io_rs2_data,
    output logic              io_busy_rs1,
    output logic              io_busy_rs2,
    input  logic              io_wb_valid,
    output logic              io_wb_ready,
    input  logic [REG_AW-1:0] io_wb_rd,
    input  logic [1:0]        io_wb_sel,
    input  logic [XLEN-1:0]   io_alu_result,
    input  logic [XLEN-1:0]   io_pc_count,
    input  logic [XLEN-1:0]   io_csr_data,
    input  logic [2:0]        io_ld_funct3,
    input  logic [1:0]        io_ld_addr_lo,
    input  logic              io_mem_rvalid,
    input  logic [XLEN-1:0]   io_mem_rdata,
    output logic              io_mem_rready,
    output logic              io_spurious
);

    logic [0:0]        r_state;
    ld_ctx_t           r_ld;
    logic              r_spurious;
    logic [XLEN-1:0]   r_regs [NREG];

    logic              w_run;
    logic              w_idle;
    logic              w_accept;
    logic              w_resp;
    logic [XLEN-1:0]   w_ld_data;
    logic              w_wen;
    logic              w_wen_nz;
    logic [REG_AW-1:0] w_waddr;
    logic [XLEN-1:0]   w_wdata;

    // reset is active-low: w_run is high whenever the block is out of reset
    assign w_run    = reset;
    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && io_wb_valid;
    assign w_resp   = (r_state == ST_LD_WAIT) && io_mem_rvalid;

    ysyx_25030077_LOAD_EXT #(
        .XLEN (XLEN)
    ) u_load_ext (
        .i_funct3  (r_ld.funct3),
        .i_addr_lo (r_ld.addr_lo),
        .i_rdata   (io_mem_rdata),
        .o_data    (w_ld_data)
    );

    // Single write port. A load response owns the port in LD_WAIT; in IDLE
    // an accepted non-load request writes its selected source.
    always_comb begin
        w_wen   = 1'b0;
        w_waddr = io_wb_rd;
        w_wdata = io_alu_result;
        if (w_resp) begin
            w_wen   = 1'b1;
            w_waddr = r_ld.rd;
            w_wdata = w_ld_data;
        end else if (w_accept && (io_wb_sel != WB_SEL_LOAD)) begin
            w_wen = 1'b1;
            case (io_wb_sel)
                WB_SEL_PC4: w_wdata = io_pc_count + XLEN'(4);
                WB_SEL_CSR: w_wdata = io_csr_data;
                default:    w_wdata = io_alu_result;
            endcase
        end
    end

    // x0 writes are dropped here so neither the array nor the bypass sees them
    assign w_wen_nz = w_run && w_wen && (w_waddr != '0);

    // Reads are combinational with same-cycle write bypass; forced to zero
    // for x0 and while reset is asserted
    assign io_rs1_data = (!w_run || (io_rs1_addr == '0)) ? '0 :
                         (w_wen_nz && (w_waddr == io_rs1_addr)) ? w_wdata :
                         r_regs[io_rs1_addr];
    assign io_rs2_data = (!w_run || (io_rs2_addr == '0)) ? '0 :
                         (w_wen_nz && (w_waddr == io_rs2_addr)) ? w_wdata :
                         r_regs[io_rs2_addr];

    // Busy drops in the response cycle because the bypass already supplies
    // the loaded value then
    assign io_busy_rs1 = w_run && (r_state == ST_LD_WAIT) && !io_mem_rvalid &&
                         (io_rs1_addr == r_ld.rd) && (io_rs1_addr != '0);
    assign io_busy_rs2 = w_run && (r_state == ST_LD_WAIT) && !io_mem_rvalid &&
                         (io_rs2_addr == r_ld.rd) && (io_rs2_addr != '0);

    assign io_wb_ready   = !w_run || w_idle;
    assign io_mem_rready = w_run && (r_state == ST_LD_WAIT);
    assign io_spurious   = r_spurious;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ld       <= '0;
            r_spurious <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wen_nz) begin
                r_regs[w_waddr] <= w_wdata;
            end
            case (r_state)
                ST_IDLE: begin
                    if (io_mem_rvalid) begin
                        r_spurious <= 1'b1;
                    end
                    if (w_accept && (io_wb_sel == WB_SEL_LOAD)) begin
                        r_ld    <= '{rd: io_wb_rd, funct3: io_ld_funct3,
                                     addr_lo: io_ld_addr_lo};
                        r_state <= ST_LD_WAIT;
                    end
                end
                ST_LD_WAIT: begin
                    if (io_mem_rvalid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25030077_reg_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_25030077_reg_wb
//  Description : Self-checking bench for ysyx_25030077_reg_wb. A behavioural
//                model (register array, pending-load record, sticky flag)
//                predicts every output; directed scenarios pin literal values
//                and a randomized phase exercises the rest.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_ysyx_25030077_reg_wb;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  io_rs1_addr, io_rs2_addr;
    logic [31:0] io_rs1_data, io_rs2_data;
    logic        io_busy_rs1, io_busy_rs2;
    logic        io_wb_valid, io_wb_ready;
    logic [4:0]  io_wb_rd;
    logic [1:0]  io_wb_sel;
    logic [31:0] io_alu_result, io_pc_count, io_csr_data;
    logic [2:0]  io_ld_funct3;
    logic [1:0]  io_ld_addr_lo;
    logic        io_mem_rvalid;
    logic [31:0] io_mem_rdata;
    logic        io_mem_rready, io_spurious;

    always #5 clock = ~clock;

    ysyx_25030077_reg_wb dut (
        .clock         (clock),
        .reset         (reset),
        .io_rs1_addr   (io_rs1_addr),
        .io_rs2_addr   (io_rs2_addr),
        .io_rs1_data   (io_rs1_data),
        .io_rs2_data   (io_rs2_data),
        .io_busy_rs1   (io_busy_rs1),
        .io_busy_rs2   (io_busy_rs2),
        .io_wb_valid   (io_wb_valid),
        .io_wb_ready   (io_wb_ready),
        .io_wb_rd      (io_wb_rd),
        .io_wb_sel     (io_wb_sel),
        .io_alu_result (io_alu_result),
        .io_pc_count   (io_pc_count),
        .io_csr_data   (io_csr_data),
        .io_ld_funct3  (io_ld_funct3),
        .io_ld_addr_lo (io_ld_addr_lo),
        .io_mem_rvalid (io_mem_rvalid),
        .io_mem_rdata  (io_mem_rdata),
        .io_mem_rready (io_mem_rready),
        .io_spurious   (io_spurious)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic        m_pending;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_lo;
    logic        m_spur;
    logic        m_we;
    logic [4:0]  m_wrd;
    logic [31:0] m_wval;
    bit          chk_en = 1'b0;
    int          n_chk  = 0;
    int          n_err  = 0;

    function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] d);
        int unsigned b, h;
        b = (d >> (8 * int'(lo))) & 32'hFF;
        h = (d >> (16 * (int'(lo) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    // What gets written this cycle, if anything
    always_comb begin
        m_we   = 1'b0;
        m_wrd  = 5'd0;
        m_wval = 32'd0;
        if (reset) begin
            if (m_pending) begin
                if (io_mem_rvalid) begin
                    m_we   = 1'b1;
                    m_wrd  = m_rd;
                    m_wval = ld_ext(m_f3, m_lo, io_mem_rdata);
                end
            end else if (io_wb_valid && io_wb_sel != 2'd2) begin
                m_we  = 1'b1;
                m_wrd = io_wb_rd;
                case (io_wb_sel)
                    2'd0:    m_wval = io_alu_result;
                    2'd1:    m_wval = io_pc_count + 32'd4;
                    default: m_wval = io_csr_data;
                endcase
            end
        end
        if (m_wrd == 5'd0) m_we = 1'b0;
    end

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            m_pending <= 1'b0;
            m_rd      <= 5'd0;
            m_f3      <= 3'd0;
            m_lo      <= 2'd0;
            m_spur    <= 1'b0;
        end else begin
            if (m_we) m_regs[m_wrd] <= m_wval;
            if (m_pending) begin
                if (io_mem_rvalid) m_pending <= 1'b0;
            end else begin
                if (io_mem_rvalid) m_spur <= 1'b1;
                if (io_wb_valid && io_wb_sel == 2'd2) begin
                    m_pending <= 1'b1;
                    m_rd      <= io_wb_rd;
                    m_f3      <= io_ld_funct3;
                    m_lo      <= io_ld_addr_lo;
                end
            end
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (!reset || a == 5'd0) return 32'd0;
        if (m_we && m_wrd == a) return m_wval;
        return m_regs[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en) begin
            check("wb_ready", {31'd0, io_wb_ready}, {31'd0, !reset || !m_pending});
            check("mem_rready", {31'd0, io_mem_rready}, {31'd0, reset && m_pending});
            check("rs1_data", io_rs1_data, exp_read(io_rs1_addr));
            check("rs2_data", io_rs2_data, exp_read(io_rs2_addr));
            check("busy_rs1", {31'd0, io_busy_rs1},
                  {31'd0, reset && m_pending && !io_mem_rvalid && io_rs1_addr == m_rd && io_rs1_addr != 0});
            check("busy_rs2", {31'd0, io_busy_rs2},
                  {31'd0, reset && m_pending && !io_mem_rvalid && io_rs2_addr == m_rd && io_rs2_addr != 0});
            check("spurious", {31'd0, io_spurious}, {31'd0, m_spur});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
        #1;
    endtask

    task automatic clr();
        io_wb_valid   = 1'b0;
        io_wb_sel     = 2'd0;
        io_wb_rd      = 5'd0;
        io_alu_result = 32'd0;
        io_pc_count   = 32'd0;
        io_csr_data   = 32'd0;
        io_ld_funct3  = 3'd0;
        io_ld_addr_lo = 2'd0;
        io_mem_rvalid = 1'b0;
        io_mem_rdata  = 32'd0;
    endtask

    // Accept a load, then respond on the very next cycle
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] data);
        io_wb_valid   = 1'b1;
        io_wb_sel     = 2'd2;
        io_wb_rd      = rd;
        io_ld_funct3  = f3;
        io_ld_addr_lo = lo;
        cyc();
        io_wb_valid   = 1'b0;
        io_mem_rvalid = 1'b1;
        io_mem_rdata  = data;
        cyc();
        io_mem_rvalid = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        io_rs1_addr = 5'd5;
        io_rs2_addr = 5'd0;
        clr();
        cyc();
        cyc();
        chk_en = 1'b1;
        at_neg();
        check("rst_ready", {31'd0, io_wb_ready}, 32'd1);
        check("rst_rready", {31'd0, io_mem_rready}, 32'd0);
        check("rst_rs1", io_rs1_data, 32'd0);
        cyc();
        reset = 1'b1;

        // ALU write with bypass
        io_wb_valid = 1'b1; io_wb_sel = 2'd0; io_wb_rd = 5'd5; io_alu_result = 32'hDEADBEEF;
        at_neg();
        check("x5_bypass", io_rs1_data, 32'hDEADBEEF);
        cyc();
        io_wb_valid = 1'b0;
        at_neg();
        check("x5_after", io_rs1_data, 32'hDEADBEEF);
        check("model_x5", m_regs[5], 32'hDEADBEEF);

        // x0 discard and pc+4
        cyc();
        io_wb_valid = 1'b1; io_wb_rd = 5'd0; io_alu_result = 32'h1234; io_rs1_addr = 5'd0;
        at_neg();
        check("x0_bypass", io_rs1_data, 32'd0);
        cyc();
        io_wb_sel = 2'd1; io_wb_rd = 5'd1; io_pc_count = 32'h80000000; io_rs2_addr = 5'd1;
        at_neg();
        check("x1_bypass", io_rs2_data, 32'h80000004);
        cyc();
        io_wb_valid = 1'b0;
        at_neg();
        check("x0_after", io_rs1_data, 32'd0);
        check("x1_after", io_rs2_data, 32'h80000004);

        // lb with three wait cycles
        cyc();
        io_wb_valid = 1'b1; io_wb_sel = 2'd2; io_wb_rd = 5'd7; io_ld_funct3 = 3'd0;
        io_ld_addr_lo = 2'd2; io_rs1_addr = 5'd7;
        at_neg();
        check("lb_accept_ready", {31'd0, io_wb_ready}, 32'd1);
        cyc();
        io_wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("lb_busy", {31'd0, io_busy_rs1}, 32'd1);
            check("lb_ready_low", {31'd0, io_wb_ready}, 32'd0);
            cyc();
        end
        io_mem_rvalid = 1'b1; io_mem_rdata = 32'h11802233;
        at_neg();
        check("lb_busy_resp", {31'd0, io_busy_rs1}, 32'd0);
        check("lb_bypass", io_rs1_data, 32'hFFFFFF80);
        cyc();
        io_mem_rvalid = 1'b0;
        at_neg();
        check("lb_x7", io_rs1_data, 32'hFFFFFF80);
        check("lb_ready_back", {31'd0, io_wb_ready}, 32'd1);

        // lhu and lw
        cyc();
        do_load(5'd8, 3'd5, 2'd2, 32'hBEEF0000);
        io_rs2_addr = 5'd8;
        at_neg();
        check("lhu_x8", io_rs2_data, 32'h0000BEEF);
        cyc();
        do_load(5'd9, 3'd2, 2'd1, 32'hCAFEF00D);
        io_rs2_addr = 5'd9;
        at_neg();
        check("lw_x9", io_rs2_data, 32'hCAFEF00D);
        check("model_x9", m_regs[9], 32'hCAFEF00D);

        // Request during LD_WAIT is ignored; spurious response in IDLE
        cyc();
        io_wb_valid = 1'b1; io_wb_sel = 2'd2; io_wb_rd = 5'd10; io_ld_funct3 = 3'd0; io_ld_addr_lo = 2'd0;
        cyc();
        io_wb_sel = 2'd0; io_wb_rd = 5'd11; io_alu_result = 32'h55; io_rs2_addr = 5'd11;
        at_neg();
        check("ldwait_ready", {31'd0, io_wb_ready}, 32'd0);
        cyc();
        io_wb_valid = 1'b0; io_mem_rvalid = 1'b1; io_mem_rdata = 32'h00000077;
        cyc();
        io_mem_rvalid = 1'b0; io_rs1_addr = 5'd10;
        at_neg();
        check("ignored_x11", io_rs2_data, 32'd0);
        check("lb_x10", io_rs1_data, 32'h00000077);
        cyc();
        io_mem_rvalid = 1'b1; io_mem_rdata = 32'hFFFFFFFF; io_rs1_addr = 5'd7;
        cyc();
        io_mem_rvalid = 1'b0;
        at_neg();
        check("spurious_set", {31'd0, io_spurious}, 32'd1);
        check("spurious_x7", io_rs1_data, 32'hFFFFFF80);

        // Reset in the middle of a load
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        io_wb_valid = 1'b1; io_wb_sel = 2'd2; io_wb_rd = 5'd12; io_ld_funct3 = 3'd2;
        cyc();
        io_wb_valid = 1'b0;
        reset = 1'b0;
        at_neg();
        check("midrst_ready", {31'd0, io_wb_ready}, 32'd1);
        cyc();
        reset = 1'b1; io_rs1_addr = 5'd5; io_rs2_addr = 5'd12;
        at_neg();
        check("midrst_x5", io_rs1_data, 32'd0);
        check("midrst_spur", {31'd0, io_spurious}, 32'd0);
        cyc();
        io_mem_rvalid = 1'b1; io_mem_rdata = 32'h00000123;
        cyc();
        io_mem_rvalid = 1'b0;
        at_neg();
        check("late_spur", {31'd0, io_spurious}, 32'd1);
        check("late_x12", io_rs2_data, 32'd0);

        // Randomized phase
        cyc();
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 199) != 0);
            io_wb_valid   = ($urandom_range(0, 1) == 1);
            io_wb_sel     = 2'($urandom_range(0, 3));
            io_wb_rd      = 5'($urandom_range(0, 31));
            io_alu_result = $urandom;
            io_pc_count   = $urandom;
            io_csr_data   = $urandom;
            io_ld_funct3  = 3'($urandom_range(0, 7));
            io_ld_addr_lo = 2'($urandom_range(0, 3));
            io_mem_rvalid = ($urandom_range(0, 2) == 0);
            io_mem_rdata  = $urandom;
            case ($urandom_range(0, 3))
                0:       io_rs1_addr = m_rd;
                1:       io_rs1_addr = io_wb_rd;
                default: io_rs1_addr = 5'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 3))
                0:       io_rs2_addr = m_rd;
                1:       io_rs2_addr = io_wb_rd;
                default: io_rs2_addr = 5'($urandom_range(0, 31));
            endcase
            cyc();
        end
        clr();
        cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_25030077_reg_wb.md
YSYX_25030077_REG_WB -- requirements
Module: ysyx_25030077_REG_WB

Interface
REQ-001 SHALL have parameter XLEN, default 32: register and data width.
REQ-002 SHALL have parameter NREG, default 32: register count; address width is log2(NREG)=5.
REQ-003 SHALL have port clock, in, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, in, 1: synchronous, active-low; 0 = reset.
REQ-005 SHALL have ports io_rs1_addr, io_rs2_addr, in, 5: read addresses.
REQ-006 SHALL have ports io_rs1_data, io_rs2_data, out, XLEN: read data.
REQ-007 SHALL have ports io_busy_rs1, io_busy_rs2, out, 1: source awaits an outstanding load; decode stalls.
REQ-008 SHALL have port io_wb_valid, in, 1: write-back request.
REQ-009 SHALL have port io_wb_ready, out, 1: request accepted when valid and ready are both 1.
REQ-010 SHALL have port io_wb_rd, in, 5: destination register.
REQ-011 SHALL have port io_wb_sel, in, 2: source select; 0 = ALU, 1 = pc+4, 2 = load, 3 = CSR.
REQ-012 SHALL have ports io_alu_result, io_pc_count and io_csr_data, in, XLEN: write-back sources.
REQ-013 SHALL have port io_ld_funct3, in, 3: load type, sampled at load accept.
REQ-014 SHALL have port io_ld_addr_lo, in, 2: byte offset, sampled at load accept.
REQ-015 SHALL have port io_mem_rvalid, in, 1: memory load response valid.
REQ-016 SHALL have port io_mem_rdata, in, XLEN: memory load response data.
REQ-017 SHALL have port io_mem_rready, out, 1: ready for memory load response.
REQ-018 SHALL have port io_spurious, out, 1: sticky flag; set by a response that arrives with no load outstanding.

Function
REQ-019 SHALL use FSM states IDLE and LD_WAIT: io_wb_ready=1 only in IDLE; io_mem_rready=1 only in LD_WAIT.
REQ-020 SHALL, on an accepted request in IDLE with sel 0/1/3, write rd with the ALU result, pc_count+4 (mod 2^32) or CSR data on the same edge.
REQ-021 SHALL, on an accepted request with sel=2, write nothing; capture rd, funct3 and addr_lo; go to LD_WAIT.
REQ-022 SHALL, in LD_WAIT with io_mem_rvalid=1, write the extended data to the captured rd and return to IDLE; no other write occurs that cycle.
REQ-023 SHALL extend load data as follows: funct3 0/4 take byte rdata[8*lo+7:8*lo] (sign-/zero-extended); 1/5 take half rdata[16*lo[1]+15:16*lo[1]] (sign/zero); 2,3,6,7 take the full word.
REQ-024 SHALL keep x0 reading 0 and discard any write to x0; a load to x0 still waits for its response.
REQ-025 SHALL read combinationally; when a write to the same non-zero address occurs that cycle, the read returns the write data (bypass).
REQ-026 SHALL drive io_busy_rsN=1 iff the state is LD_WAIT, rsN equals the captured rd, and rsN != 0; it deasserts in the response cycle, which bypasses per REQ-025.
REQ-027 SHALL allow one outstanding load at most; io_wb_valid is ignored in LD_WAIT.
REQ-028 SHALL, on io_mem_rvalid in IDLE, leave registers unchanged and set io_spurious, which is cleared only by reset.

Reset
REQ-029 SHALL, with reset=0 at an edge, clear all registers, enter IDLE, clear the captured load fields and io_spurious.
REQ-030 SHALL output during reset: io_wb_ready=1, io_mem_rready=0, busy=0, read data=0.
REQ-031 SHALL abandon a load interrupted by reset in LD_WAIT; a late response then counts as spurious.

Structure
REQ-032 SHALL place the WB_SEL codes, state encoding, load funct3 codes and XLEN in the shared package ysyx_25030077_pkg.
REQ-033 SHALL implement extraction and extension in the combinational sub-module ysyx_25030077_LOAD_EXT.

Verification
REQ-034 SHALL cover ALU write then read: sel=0, rd=5, alu=0xDEADBEEF -> x5 reads 0xDEADBEEF on the same-cycle bypass and after.
REQ-035 SHALL cover x0: sel=0, rd=0, alu=0x1234 -> x0 reads 0; sel=1, rd=1, pc=0x80000000 -> x1=0x80000004.
REQ-036 SHALL cover lb: lb to rd=7, lo=2; 3 wait cycles, then rdata=0x11802233 -> busy_rs1 (rs1=7) high for 3 cycles; x7=0xFFFFFF80; ready low until return.
REQ-037 SHALL cover lhu: lhu to rd=8, lo=2; rdata=0xBEEF0000 -> x8=0x0000BEEF; lw -> full word.
REQ-038 SHALL cover busy stall: wb_valid asserted in LD_WAIT -> not written; spurious rvalid in IDLE -> registers unchanged, io_spurious=1.
REQ-039 SHALL cover reset mid-load: reset in LD_WAIT -> all registers 0, IDLE; a later response sets io_spurious and writes nothing.
